// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter fed from an 8-entry byte FIFO read port.
//
// Pops one byte at a time (registered single-cycle fifo_rd_en pulse), waits one
// cycle for the FIFO's registered dout, then shifts out start, 8 data bits
// LSB-first, optional even parity and a stop bit, each CLKS_PER_BIT cycles long.
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (11-bit frame instead of 10).
//
// Ports:
//   clk         system clock, shared with the FIFO read clock
//   rst         asynchronous active-high reset
//   fifo_empty  FIFO empty flag, sampled only while idle
//   fifo_rd_en  FIFO pop request, one-cycle registered pulse per byte
//   fifo_dout   FIFO read data, valid the cycle after the pop edge
//   txd         serial output, idles high
//   busy        high from the pop request until the end of the stop bit

module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_dout,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned TimerW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StStart  = 3'd3;
  localparam logic [2:0] StData   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd5;
`endif
  localparam logic [2:0] StStop   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              rd_en_q, rd_en_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic bit_end;
  assign bit_end = (timer_q == TimerMax);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    rd_en_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          state_d = StFetch;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      // The FIFO pops on this edge; its dout is valid one cycle later.
      StFetch: begin
        state_d = StWait;
      end
      StWait: begin
        shift_d = fifo_dout;
        timer_d = '0;
        idx_d   = '0;
        txd_d   = 1'b0;
        state_d = StStart;
`ifdef UART_TX_PARITY_EN
        // Capture parity now, the shift register is consumed during DATA.
        parity_d = ^fifo_dout;
`endif
      end
      StStart: begin
        if (bit_end) begin
          timer_d = '0;
          txd_d   = shift_q[0];
          state_d = StData;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            txd_d   = parity_q;
            state_d = StParity;
`else
            txd_d   = 1'b1;
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = shift_q[1];
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          timer_d = '0;
          txd_d   = 1'b1;
          state_d = StStop;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
`endif
      StStop: begin
        txd_d = 1'b1;
        if (bit_end) begin
          timer_d = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      rd_en_q <= rd_en_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign fifo_rd_en = rd_en_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with a behavioural FIFO and a frame-level reference model.
module tb_uart_tx;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_dout = 8'h00;
  logic       txd;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int bad_pops = 0;
  int last_stop = 0;

  // Behavioural FIFO: unbounded array indexed by push/pop counters.
  logic [7:0] mem [256];
  int push_cnt = 0;
  int pop_cnt = 0;
  assign fifo_empty = (push_cnt == pop_cnt);

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .txd        (txd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      rd_pulses <= rd_pulses + 1;
      if (fifo_empty) bad_pops <= bad_pops + 1;
      else begin
        fifo_dout <= mem[pop_cnt[7:0]];
        pop_cnt   <= pop_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[push_cnt[7:0]] = b;
    push_cnt++;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, " txd"}, txd, 1);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " rd_en"}, fifo_rd_en, 0);
    end
  endtask

  // Waits (bounded) for the pop pulse and returns the number of extra cycles waited.
  task automatic wait_pulse(output int w);
    w = 0;
    @(negedge clk);
    while (fifo_rd_en !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
  endtask

  // Expects one complete frame for byte b, starting at the pop request.
  task automatic run_frame(input logic [7:0] b, input bit b2b, input string tag);
    logic exp_bits [FB];
    logic [7:0] rx;
    int w, e0, k;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    exp_bits[9] = ^b;
`endif
    exp_bits[FB-1] = 1'b1;
    rx = 8'h00;
    wait_pulse(w);
    chk({tag, " pop pulse"}, fifo_rd_en, 1);
    chk({tag, " fetch latency"}, w, 0);
    chk({tag, " busy at pop"}, busy, 1);
    e0 = cyc;
    if (b2b) chk({tag, " gap stop->fall"}, (e0 + 2) - last_stop, N + 3);
    @(negedge clk);
    chk({tag, " pulse width"}, fifo_rd_en, 0);
    chk({tag, " txd before start"}, txd, 1);
    for (int t = 0; t < FB * N; t++) begin
      @(negedge clk);
      k = t / N;
      chk({tag, " txd bit"}, txd, exp_bits[k]);
      chk({tag, " busy in frame"}, busy, 1);
      if (t == 0) chk({tag, " fall time"}, cyc - e0, 2);
      if (t == (FB - 1) * N) last_stop = cyc;
      if ((t % N) == N / 2 && k >= 1 && k <= 8) rx[k-1] = txd;
    end
    chk({tag, " rx byte"}, rx, b);
    @(negedge clk);
    chk({tag, " busy after stop"}, busy, 0);
  endtask

  initial begin
    int w;
    logic [7:0] rnd [5];

    // Reset and long idle with an empty FIFO.
    idle_cycles(3, "in reset");
    rst = 1'b0;
    idle_cycles(100, "idle");
    chk("idle no pops", rd_pulses, 0);

    // Single byte 0x55.
    push(8'h55);
    run_frame(8'h55, 1'b0, "f55");
    chk("f55 pulses", rd_pulses, 1);

    // Two back-to-back frames.
    push(8'hA5);
    push(8'h3C);
    run_frame(8'hA5, 1'b0, "fA5");
    run_frame(8'h3C, 1'b1, "f3C");
    chk("two frames fifo empty", fifo_empty, 1);
    chk("two frames pulses", rd_pulses, 3);
    idle_cycles(5, "post f3C");

    // Reset during data bit 3 of 0xFF.
    push(8'hFF);
    wait_pulse(w);
    chk("rst pop pulse", fifo_rd_en, 1);
    @(negedge clk);
    for (int t = 0; t <= 4 * N + 1; t++) @(negedge clk);
    chk("rst busy before", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst txd", txd, 1);
    chk("rst busy", busy, 0);
    chk("rst rd_en", fifo_rd_en, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(50, "after rst");
    chk("rst pulses", rd_pulses, 4);
    chk("rst fifo empty", fifo_empty, 1);

    // Full FIFO burst 0x00..0x06.
    for (int i = 0; i < 7; i++) push(8'(i));
    for (int i = 0; i < 7; i++) run_frame(8'(i), i > 0, "burst");
    chk("burst pulses", rd_pulses, 11);
    chk("burst fifo empty", fifo_empty, 1);

    // Random bytes.
    for (int i = 0; i < 5; i++) begin
      rnd[i] = 8'($urandom_range(0, 255));
      push(rnd[i]);
    end
    for (int i = 0; i < 5; i++) run_frame(rnd[i], i > 0, "rand");
    chk("rand pulses", rd_pulses, 16);
    idle_cycles(10, "final idle");
    chk("no pop while empty", bad_pops, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
